// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external 32-bit ALU between two
// requesters. An operation is accepted with a valid/ready handshake. Its
// operands are then held on the ALU ports for EXEC_CYCLES cycles. The ALU
// result is then captured. It is returned to the requester that issued the
// operation through that requester's own valid/ready response channel.

module alu_arbiter_checker (
    input logic clk,
    input logic reset_n,
    input logic req0_valid,
    input logic req1_valid,
    input logic req0_ready,
    input logic req1_ready,
    input logic rsp0_valid,
    input logic rsp1_valid
);

    // Only one requester may be granted in a cycle.
    a_one_ready: assert property (@(posedge clk) disable iff (!reset_n)
        !(req0_ready && req1_ready));

    // A response is owned by exactly one requester.
    a_one_rsp: assert property (@(posedge clk) disable iff (!reset_n)
        !(rsp0_valid && rsp1_valid));

    // A grant is only offered to a requester that is asking.
    a_ready0_needs_valid: assert property (@(posedge clk) disable iff (!reset_n)
        req0_ready |-> req0_valid);
    a_ready1_needs_valid: assert property (@(posedge clk) disable iff (!reset_n)
        req1_ready |-> req1_valid);

    // No new operation is accepted while a response is pending.
    a_no_grant_in_resp: assert property (@(posedge clk) disable iff (!reset_n)
        (rsp0_valid || rsp1_valid) |-> !(req0_ready || req1_ready));

endmodule

module alu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_y,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] alu_y
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The counter counts EXEC_CYCLES-1 down to zero. The result is captured on the
    // edge where the counter is already zero, which gives EXEC_CYCLES edges in EXEC.
    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        grant_r;        // requester owning the in-flight operation
    logic        last_grant_r;   // requester granted most recently (tie-break)
    logic        rsp0_valid_r;
    logic        rsp1_valid_r;
    logic [31:0] rsp_y_r;
    logic [31:0] alu_a_r;
    logic [31:0] alu_b_r;
    logic [3:0]  alu_opcode_r;

    logic        grant0_s;
    logic        grant1_s;
    logic        grant_any_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    logic [3:0]  sel_op_s;
    logic        rsp_fire_s;

    // Round-robin grant: ready is only offered in IDLE. When both requesters ask,
    // the one not served last time wins.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req0_valid && req1_valid) begin
                    if (last_grant_r) begin
                        grant0_s = 1'b1;
                    end else begin
                        grant1_s = 1'b1;
                    end
                end else if (req0_valid) begin
                    grant0_s = 1'b1;
                end else if (req1_valid) begin
                    grant1_s = 1'b1;
                end else begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                end
            end
            default: begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        endcase
    end

    // Operand selection from the granted requester.
    always_comb begin
        sel_a_s  = req0_a;
        sel_b_s  = req0_b;
        sel_op_s = req0_op;
        if (grant1_s) begin
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
            sel_op_s = req1_op;
        end else begin
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
            sel_op_s = req0_op;
        end
    end

    // The response completes only on the owning requester's ready. The other
    // requester's ready is ignored.
    always_comb begin
        rsp_fire_s = 1'b0;
        if (grant_r) begin
            rsp_fire_s = rsp1_valid_r && rsp1_ready;
        end else begin
            rsp_fire_s = rsp0_valid_r && rsp0_ready;
        end
    end

    assign grant_any_s = grant0_s | grant1_s;

    // Arbitration FSM: latch the operation, hold the ALU inputs, capture the result,
    // then hold the response until the owner takes it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp_y_r      <= 32'd0;
            alu_a_r      <= 32'd0;
            alu_b_r      <= 32'd0;
            alu_opcode_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_any_s) begin
                        alu_a_r      <= sel_a_s;
                        alu_b_r      <= sel_b_s;
                        alu_opcode_r <= sel_op_s;
                        grant_r      <= grant1_s;
                        last_grant_r <= grant1_s;
                        cnt_r        <= CNT_LOAD;
                        state_r      <= ST_EXEC;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        rsp_y_r      <= alu_y;
                        rsp0_valid_r <= ~grant_r;
                        rsp1_valid_r <= grant_r;
                        state_r      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_fire_s) begin
                        rsp0_valid_r <= 1'b0;
                        rsp1_valid_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r      <= ST_RESP;
                    end
                end
                default: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp_y      = rsp_y_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_opcode = alu_opcode_r;

    alu_arbiter_checker u_checker (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (grant0_s),
        .req1_ready (grant1_s),
        .rsp0_valid (rsp0_valid_r),
        .rsp1_valid (rsp1_valid_r)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. Two instances, EXEC_CYCLES=1 and EXEC_CYCLES=3,
// share the requester and response-ready inputs. Each instance drives its own
// behavioural ALU. Each test looks at one instance (index d: 0 -> E=1, 1 -> E=3).
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_ready, rsp1_ready;

    logic [1:0]       req0_ready_d, req1_ready_d, rsp0_valid_d, rsp1_valid_d;
    logic [1:0][31:0] rsp_y_d, alu_a_d, alu_b_d, alu_y_d;
    logic [1:0][3:0]  alu_op_d;

    int checks = 0;
    int failures = 0;

    // Behavioural ALU attached to the DUT ALU ports.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a ^ b;
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return a * b;
            4'd6:    return a << b[4:0];
            4'd7:    return a >> b[4:0];
            4'd8:    return 32'($signed(a) >>> b[4:0]);
            4'd9:    return ~(a | b);
            4'd10:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd11:   return (a < b) ? 32'd1 : 32'd0;
            4'd12:   return a;
            4'd13:   return b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_y_d[0] = alu_fn(alu_a_d[0], alu_b_d[0], alu_op_d[0]);
    assign alu_y_d[1] = alu_fn(alu_a_d[1], alu_b_d[1], alu_op_d[1]);

    alu_arbiter #(.EXEC_CYCLES(1)) dut_e1 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready_d[0]),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready_d[0]),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid_d[0]), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid_d[0]), .rsp1_ready(rsp1_ready),
        .rsp_y(rsp_y_d[0]), .alu_a(alu_a_d[0]), .alu_b(alu_b_d[0]),
        .alu_opcode(alu_op_d[0]), .alu_y(alu_y_d[0])
    );

    alu_arbiter #(.EXEC_CYCLES(3)) dut_e3 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready_d[1]),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready_d[1]),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid_d[1]), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid_d[1]), .rsp1_ready(rsp1_ready),
        .rsp_y(rsp_y_d[1]), .alu_a(alu_a_d[1]), .alu_b(alu_b_d[1]),
        .alu_opcode(alu_op_d[1]), .alu_y(alu_y_d[1])
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'd0; req0_b = 32'd0; req0_op = 4'd0;
        req1_a = 32'd0; req1_b = 32'd0; req1_op = 4'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rsp0_valid_d[d] !== 1'b0 || rsp1_valid_d[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_rsp_valid d=%0d got=%b%b exp=00", d, rsp0_valid_d[d], rsp1_valid_d[d]);
            end
            checks++;
            if (rsp_y_d[d] !== 32'd0 || alu_a_d[d] !== 32'd0 || alu_b_d[d] !== 32'd0 || alu_op_d[d] !== 4'd0) begin
                failures++;
                $display("FAIL reset_data d=%0d got y=%h a=%h b=%h op=%h exp all 0",
                         d, rsp_y_d[d], alu_a_d[d], alu_b_d[d], alu_op_d[d]);
            end
        end
        reset_n = 1'b1;
    endtask

    // ADD 5+7 with EXEC_CYCLES=1.
    task automatic test_single();
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 4'd3;
        #1;
        checks++;
        if (req0_ready_d[0] !== 1'b1 || req1_ready_d[0] !== 1'b0) begin
            failures++;
            $display("FAIL single_ready got=%b%b exp=10", req0_ready_d[0], req1_ready_d[0]);
        end
        @(negedge clk);
        req0_valid = 1'b0; req0_a = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (rsp0_valid_d[0] !== 1'b0 || alu_a_d[0] !== 32'd5 || alu_b_d[0] !== 32'd7 || alu_op_d[0] !== 4'd3) begin
            failures++;
            $display("FAIL single_exec got v=%b a=%h b=%h op=%h exp v=0 a=5 b=7 op=3",
                     rsp0_valid_d[0], alu_a_d[0], alu_b_d[0], alu_op_d[0]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp0_valid_d[0] !== 1'b1 || rsp_y_d[0] !== 32'd12) begin
            failures++;
            $display("FAIL single_rsp got v=%b y=%0d exp v=1 y=12", rsp0_valid_d[0], rsp_y_d[0]);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (rsp0_valid_d[0] !== 1'b0) begin
            failures++;
            $display("FAIL single_done got=%b exp=0", rsp0_valid_d[0]);
        end
        rsp0_ready = 1'b0;
    endtask

    // Tie after reset: req0 (SUB 10-3) first, then req1 (MULTU 6*7).
    task automatic test_tie();
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_op = 4'd4;
        req1_valid = 1'b1; req1_a = 32'd6;  req1_b = 32'd7; req1_op = 4'd5;
        #1;
        checks++;
        if (req0_ready_d[0] !== 1'b1 || req1_ready_d[0] !== 1'b0) begin
            failures++;
            $display("FAIL tie_first got=%b%b exp=10", req0_ready_d[0], req1_ready_d[0]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (req1_ready_d[0] !== 1'b0) begin
            failures++;
            $display("FAIL tie_busy_ready got=%b exp=0", req1_ready_d[0]);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++;
        if (rsp0_valid_d[0] !== 1'b1 || rsp_y_d[0] !== 32'd7 || req1_ready_d[0] !== 1'b0) begin
            failures++;
            $display("FAIL tie_rsp0 got v=%b y=%0d r1=%b exp v=1 y=7 r1=0",
                     rsp0_valid_d[0], rsp_y_d[0], req1_ready_d[0]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (req1_ready_d[0] !== 1'b1) begin
            failures++;
            $display("FAIL tie_second_ready got=%b exp=1", req1_ready_d[0]);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp1_valid_d[0] !== 1'b1 || rsp0_valid_d[0] !== 1'b0 || rsp_y_d[0] !== 32'd42) begin
            failures++;
            $display("FAIL tie_rsp1 got v1=%b v0=%b y=%0d exp v1=1 v0=0 y=42",
                     rsp1_valid_d[0], rsp0_valid_d[0], rsp_y_d[0]);
        end
        idle_inputs();
    endtask

    // Both requesters always valid: grants alternate 0,1,0,1.
    task automatic test_alternate();
        int grants[$];
        int cyc;
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        cyc = 0;
        while (grants.size() < 4 && cyc < 40) begin
            req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
            #1;
            checks++;
            if (req0_ready_d[0] && req1_ready_d[0]) begin
                failures++;
                $display("FAIL alt_both_ready cycle=%0d got=11 exp at most one", cyc);
            end
            if (req0_ready_d[0] === 1'b1) grants.push_back(0);
            if (req1_ready_d[0] === 1'b1) grants.push_back(1);
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (grants.size() != 4) begin
            failures++;
            $display("FAIL alt_count got=%0d exp=4", grants.size());
        end else begin
            checks++;
            if (grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
                failures++;
                $display("FAIL alt_order got=%0d%0d%0d%0d exp=0101", grants[0], grants[1], grants[2], grants[3]);
            end
        end
        idle_inputs();
    endtask

    // Response back-pressure: result held while rsp0_ready is low.
    task automatic test_backpressure();
        logic [31:0] a, b, exp_y;
        int i;
        do_reset();
        a = $urandom; b = $urandom; exp_y = a + b;
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = 4'd3;
        @(negedge clk);
        req0_a = $urandom; req1_valid = 1'b1; req1_a = $urandom; req1_op = 4'd2;
        #1;
        i = 0;
        while (rsp0_valid_d[0] !== 1'b1 && i < 10) begin
            @(negedge clk);
            #1;
            i++;
        end
        checks++;
        if (rsp0_valid_d[0] !== 1'b1) begin
            failures++;
            $display("FAIL bp_timeout got rsp0_valid=%b exp=1 within 10 cycles", rsp0_valid_d[0]);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rsp0_valid_d[0] !== 1'b1 || rsp_y_d[0] !== exp_y || req0_ready_d[0] !== 1'b0 || req1_ready_d[0] !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold k=%0d got v=%b y=%h r=%b%b exp v=1 y=%h r=00",
                         k, rsp0_valid_d[0], rsp_y_d[0], req0_ready_d[0], req1_ready_d[0], exp_y);
            end
            @(negedge clk);
            #1;
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (rsp0_valid_d[0] !== 1'b0 || req1_ready_d[0] !== 1'b1 || req0_ready_d[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got v=%b r=%b%b exp v=0 r=01",
                     rsp0_valid_d[0], req0_ready_d[0], req1_ready_d[0]);
        end
        idle_inputs();
    endtask

    // Reset during EXEC (EXEC_CYCLES=3) drops the operation.
    task automatic test_midreset();
        logic seen;
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = $urandom | 32'd1; req0_b = $urandom; req0_op = 4'd3;
        @(negedge clk);
        req0_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (rsp0_valid_d[1] !== 1'b0 || rsp1_valid_d[1] !== 1'b0 || rsp_y_d[1] !== 32'd0 || alu_a_d[1] !== 32'd0) begin
            failures++;
            $display("FAIL midreset_state got v=%b%b y=%h a=%h exp v=00 y=0 a=0",
                     rsp0_valid_d[1], rsp1_valid_d[1], rsp_y_d[1], alu_a_d[1]);
        end
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req1_ready_d[1] !== 1'b1) begin
            failures++;
            $display("FAIL midreset_idle got req1_ready=%b exp=1", req1_ready_d[1]);
        end
        req1_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (rsp0_valid_d[1] === 1'b1 || rsp1_valid_d[1] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midreset_dropped got response=%b exp=0", seen);
        end
        idle_inputs();
    endtask

    // EXEC_CYCLES=3: SLT -1 < 1 on requester 1.
    task automatic test_exec3();
        do_reset();
        rsp1_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_op = 4'hA;
        #1;
        checks++;
        if (req1_ready_d[1] !== 1'b1) begin
            failures++;
            $display("FAIL exec3_ready got=%b exp=1", req1_ready_d[1]);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            req1_valid = 1'b0; req1_a = $urandom; req1_op = 4'd0;
            #1;
            checks++;
            if (rsp1_valid_d[1] !== 1'b0 || alu_a_d[1] !== 32'hFFFF_FFFF || alu_b_d[1] !== 32'd1 || alu_op_d[1] !== 4'hA) begin
                failures++;
                $display("FAIL exec3_hold k=%0d got v=%b a=%h b=%h op=%h exp v=0 a=ffffffff b=1 op=a",
                         k, rsp1_valid_d[1], alu_a_d[1], alu_b_d[1], alu_op_d[1]);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp1_valid_d[1] !== 1'b1 || rsp_y_d[1] !== 32'd1) begin
            failures++;
            $display("FAIL exec3_rsp got v=%b y=%h exp v=1 y=1", rsp1_valid_d[1], rsp_y_d[1]);
        end
        idle_inputs();
    endtask

    // Random traffic against a transaction-level model: idle/wait/respond phases.
    task automatic test_random(input int d, input int e, input int n);
        int          phase;   // 0 idle, 1 computing, 2 responding
        int          wcnt;
        int          owner;
        int          last;
        logic [31:0] ma, mb, mexp;
        logic [3:0]  mop;
        logic        e0, e1;
        do_reset();
        phase = 0; wcnt = 0; owner = 0; last = 1;
        ma = 32'd0; mb = 32'd0; mop = 4'd0; mexp = 32'd0;
        for (int c = 0; c < n; c++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a = $urandom; req0_b = $urandom_range(0, 40); req0_op = 4'($urandom_range(0, 15));
            req1_a = $urandom; req1_b = $urandom;              req1_op = 4'($urandom_range(0, 15));
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            #1;
            e0 = (phase == 0) && req0_valid && (!req1_valid || last == 1);
            e1 = (phase == 0) && req1_valid && (!req0_valid || last == 0);
            checks++;
            if (req0_ready_d[d] !== e0 || req1_ready_d[d] !== e1) begin
                failures++;
                $display("FAIL rnd_ready d=%0d c=%0d got=%b%b exp=%b%b", d, c,
                         req0_ready_d[d], req1_ready_d[d], e0, e1);
            end
            checks++;
            if (rsp0_valid_d[d] !== (phase == 2 && owner == 0) || rsp1_valid_d[d] !== (phase == 2 && owner == 1)) begin
                failures++;
                $display("FAIL rnd_rsp_valid d=%0d c=%0d got=%b%b exp=%b%b", d, c,
                         rsp0_valid_d[d], rsp1_valid_d[d], (phase == 2 && owner == 0), (phase == 2 && owner == 1));
            end
            if (phase == 2) begin
                checks++;
                if (rsp_y_d[d] !== mexp) begin
                    failures++;
                    $display("FAIL rnd_rsp_y d=%0d c=%0d got=%h exp=%h", d, c, rsp_y_d[d], mexp);
                end
            end
            if (phase != 0) begin
                checks++;
                if (alu_a_d[d] !== ma || alu_b_d[d] !== mb || alu_op_d[d] !== mop) begin
                    failures++;
                    $display("FAIL rnd_alu_in d=%0d c=%0d got a=%h b=%h op=%h exp a=%h b=%h op=%h",
                             d, c, alu_a_d[d], alu_b_d[d], alu_op_d[d], ma, mb, mop);
                end
            end
            case (phase)
                0: begin
                    if (e0 || e1) begin
                        owner = e1 ? 1 : 0;
                        last  = owner;
                        ma    = e1 ? req1_a  : req0_a;
                        mb    = e1 ? req1_b  : req0_b;
                        mop   = e1 ? req1_op : req0_op;
                        mexp  = alu_fn(ma, mb, mop);
                        wcnt  = e;
                        phase = 1;
                    end
                end
                1: begin
                    wcnt--;
                    if (wcnt == 0) phase = 2;
                end
                default: begin
                    if ((owner == 0 && rsp0_ready) || (owner == 1 && rsp1_ready)) phase = 0;
                end
            endcase
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_tie();
        test_alternate();
        test_backpressure();
        test_midreset();
        test_exec3();
        test_random(0, 1, 300);
        test_random(1, 3, 300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
